// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control unit for a multi-cycle RV32I core that supports lw, sw, R-type,
// I-type ALU, beq and jal. Each instruction is walked through a Moore state
// machine. The datapath mux selects and write enables are decoded from the
// current state. The ALU control and immediate-format select are decoded from
// the instruction fields.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   op            in   instr[6:0]
//   funct3        in   instr[14:12]
//   funct7b5      in   instr[30]
//   zero          in   ALU result-is-zero flag (branch resolution)
//   mem_ready     in   memory completes the current access this cycle
//   pc_write      out  load PC
//   ir_write      out  load IR and old_pc
//   adr_src       out  memory address select: 0=PC, 1=result
//   mem_write     out  memory write enable
//   reg_write     out  register file write enable
//   alu_src_a     out  00=PC, 01=old_pc, 10=rd1
//   alu_src_b     out  00=rd2, 01=imm_ext, 10=constant 4
//   result_src    out  00=alu_out, 01=mem data, 10=alu_result
//   imm_src       out  00=I, 01=S, 10=B, 11=J
//   alu_control   out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal_instr out  one-cycle pulse in DECODE on an unsupported instruction
//   state         out  current state, for debug
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr,
  output logic [3:0] state
);

  // Opcodes handled by this core
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  w_alu_op;
  logic        w_pc_update;
  logic        w_branch;
  logic        w_ir_write;
  logic        w_mem_write;
  logic        w_reg_write;
  logic        w_illegal;

  // ALU decoder: alu_op 00 forces add, 01 forces sub, 10 decodes funct3.
  // Subtract is only chosen for R-type (op[5]=1); addi ignores funct7b5,
  // since instr[30] is part of its immediate.
  function automatic logic [2:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [2:0] f3,
                                            input logic       op5,
                                            input logic       f7b5);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    case (alu_op)
      2'b00: ctl = ALU_ADD;
      2'b01: ctl = ALU_SUB;
      2'b10: begin
        case (f3)
          3'b000:  ctl = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctl = ALU_SLT;
          3'b110:  ctl = ALU_OR;
          3'b111:  ctl = ALU_AND;
          default: ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // Immediate-format select depends only on the opcode
  function automatic logic [1:0] imm_decode(input logic [6:0] opc);
    logic [1:0] sel;
    case (opc)
      OP_STORE:  sel = 2'b01;
      OP_BRANCH: sel = 2'b10;
      OP_JAL:    sel = 2'b11;
      default:   sel = 2'b00;
    endcase
    return sel;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next      = r_state;
    w_alu_op    = 2'b00;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;

    case (r_state)
      S_FETCH: begin
        // PC+4 is computed on the ALU and loaded directly into the PC
        // in the same cycle the instruction word arrives.
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        w_ir_write  = mem_ready;
        w_pc_update = mem_ready;
        if (mem_ready) begin
          w_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Precompute the branch/jump target into alu_out
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_JAL:            w_next = S_JAL;
          OP_BRANCH: begin
            if (funct3 == 3'b000) begin
              w_next = S_BEQ;
            end else begin
              w_next    = S_FETCH;
              w_illegal = 1'b1;
            end
          end
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        // op[5] separates store (0100011) from load (0000011)
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end

      S_MEMWRITE: begin
        // Write enable stays high for the whole access, including waits
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end
      end

      S_EXECUTER: begin
        alu_src_a = 2'b10;
        w_alu_op  = 2'b10;
        w_next    = S_ALUWB;
      end

      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_alu_op  = 2'b10;
        w_next    = S_ALUWB;
      end

      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end

      S_BEQ: begin
        // alu_out holds the target from DECODE; zero comes from rs1-rs2
        alu_src_a = 2'b10;
        w_alu_op  = 2'b01;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end

      S_JAL: begin
        // PC <- target (alu_out); ALU computes old_pc+4 for the link write
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Write enables are gated by rst_n so that nothing commits while reset is
  // held, even though FETCH itself would otherwise follow mem_ready.
  assign pc_write      = rst_n & (w_pc_update | (w_branch & zero));
  assign ir_write      = rst_n & w_ir_write;
  assign mem_write     = rst_n & w_mem_write;
  assign reg_write     = rst_n & w_reg_write;
  assign illegal_instr = rst_n & w_illegal;

  assign alu_control   = alu_decode(w_alu_op, funct3, op[5], funct7b5);
  assign imm_src       = imm_decode(op);
  assign state         = r_state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

- Main control unit for the multi-cycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences each instruction through a Moore state machine and drives the datapath mux selects and write enables.
- Drives `alu_control` (3-bit ALU encoding) and consumes the ALU's `zero` flag to resolve branches.
- Sits between the instruction register and the shared-memory datapath; memory accesses wait on a ready handshake.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: instr[6:0]. `funct3` in 3: instr[14:12]. `funct7b5` in 1: instr[30].
- `zero` in 1: ALU result-is-zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: load PC.
- `ir_write` out 1: load IR and old_pc.
- `adr_src` out 1: memory address; 0=PC, 1=result.
- `mem_write` out 1: memory write enable.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: 00=PC, 01=old_pc, 10=rd1.
- `alu_src_b` out 2: 00=rd2, 01=imm_ext, 10=constant 4.
- `result_src` out 2: 00=alu_out (registered), 01=mem data, 10=alu_result.
- `imm_src` out 2: 00=I, 01=S, 10=B, 11=J.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal_instr` out 1: one-cycle pulse on an unsupported instruction.
- `state` out 4: current state, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Unlisted outputs are 0; `alu_op` is internal.
- FETCH:
  - Outputs: adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10, ir_write=mem_ready, pc_update=mem_ready.
  - Holds until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: src_a=01, src_b=01, alu_op=00 (branch target into alu_out).
  - lw (0000011) / sw (0100011) → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1100011 with funct3=000 → BEQ.
  - 1101111 → JAL.
  - Anything else → FETCH with illegal_instr=1.
- MEMADR: src_a=10, src_b=01, alu_op=00. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then → MEMWB.
- MEMWB: result_src=01, reg_write=1. → FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, held continuously. Holds until mem_ready, then → FETCH.
- EXECUTER: src_a=10, src_b=00, alu_op=10. → ALUWB.
- EXECUTEI: src_a=10, src_b=01, alu_op=10. → ALUWB.
- ALUWB: result_src=00, reg_write=1. → FETCH.
- BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1. → FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1. → ALUWB.
- pc_write = pc_update | (branch & zero).
- ALU decode (combinational):
  - alu_op 00 → add; 01 → sub.
  - alu_op 10, by funct3:
    - 000: sub if {op[5],funct7b5}=11, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Any other funct3: add (not flagged illegal).
- imm_src from op (combinational): 0100011→01, 1100011→10, 1101111→11, else 00.

## Timing
- While rst_n=0:
  - state=FETCH.
  - pc_write, ir_write, mem_write, reg_write and illegal_instr forced 0.
  - Selects show FETCH values: adr_src=0, src_a=00, src_b=10, result_src=10, alu_control=000.
- Reset is asynchronous; release takes effect at the first clk edge with rst_n=1.
- Reset mid-instruction aborts it; no write enable is asserted afterward.
- All outputs are combinational from state and instruction fields; state updates on the rising clk edge only.
- Cycle counts with zero-wait memory:
  - lw 5; sw 4; R/I-type 4; beq 3; jal 4; illegal 2.
- Each wait cycle (mem_ready=0) in FETCH, MEMREAD or MEMWRITE adds one cycle and holds all outputs stable.
- mem_ready is ignored in every other state.
- illegal_instr is high only in the DECODE cycle.

## Test plan
- Reset:
  - Stimulus: rst_n low mid-ALUWB.
  - Response: reg_write drops immediately; state=FETCH; after release, FETCH with mem_ready=1 gives ir_write=1, pc_write=1 for exactly one cycle.
- `add x3,x1,x2` then `sub` (funct7b5=1):
  - Stimulus: both executed with zero-wait memory.
  - Response: sequence FETCH,DECODE,EXECUTER,ALUWB; alu_control 000 for add, 001 for sub in EXECUTER; reg_write=1 only in ALUWB.
- lw with mem_ready low for 2 cycles in MEMREAD:
  - Response: 7 total cycles; adr_src=1 held throughout MEMREAD; reg_write=1 with result_src=01 only in MEMWB.
- beq (op=1100011, funct3=000):
  - Stimulus: zero=1, then zero=0.
  - Response: pc_write=1 in BEQ only when zero=1; alu_control=001 in BEQ.
- jal:
  - Response: sequence FETCH,DECODE,JAL,ALUWB; imm_src=11; pc_write=1 in JAL; src_a=01 and src_b=10 in JAL.
- Illegal instructions:
  - Stimulus: op=0000000, then beq-opcode with funct3=001.
  - Response: illegal_instr pulses once in DECODE; next state FETCH; no write enable asserted.
